// File: rtl/sd_block_read_responder_pkg.sv
// Shared SD block-read constants, FSM state encoding and emitted-byte payload
// for the memory-backed block-read responder.
package sd_block_read_responder_pkg;

    localparam int unsigned SD_BLOCK_ADDR_BITS   = 32;
    localparam int unsigned SD_BLOCK_LENGHT_BITS = 9;
    localparam int unsigned SD_LAST_BLOCK_BYTE   = 511;
    localparam int unsigned DELAY_BITS           = 8;

    typedef logic [SD_BLOCK_ADDR_BITS-1:0]   blk_addr_t;
    typedef logic [SD_BLOCK_LENGHT_BITS-1:0] blk_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATENCY,
        ST_FETCH,
        ST_EMIT,
        ST_GAP,
        ST_BLOCK_END
    } block_resp_state_t;

    typedef struct packed {
        blk_idx_t   idx;
        logic [7:0] data;
    } block_resp_beat_t;

endpackage

// File: rtl/block_resp_delay.sv
// Loadable down-counter with a done flag; paces start latency and inter-byte gaps.
module block_resp_delay
    import sd_block_read_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DELAY_BITS-1:0] load_val,
    output logic                  done_c
);

    logic [DELAY_BITS-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/sd_block_read_responder.sv
// Card-side SD block-read responder serving 512-byte blocks from a byte-wide memory image.
// Optional macro BLOCK_RESP_RANGE_CHECK_EN: blocks beyond the image read as zeros and raise err_out_of_range.
module sd_block_read_responder
    import sd_block_read_responder_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS = 20,
    parameter int unsigned START_LATENCY = 8,
    parameter int unsigned BYTE_GAP      = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          block_read_trigger,
    input  logic                          block_read_continous_mode,
    input  logic [SD_BLOCK_ADDR_BITS-1:0] block_read_block_addr,
    output logic                          block_read_card_ready,
    output logic [7:0]                    block_read_data,
    output logic [SD_BLOCK_LENGHT_BITS-1:0] block_read_data_idx,
    output logic                          block_read_data_new_flag,
    output logic                          mem_rd_en,
    output logic [MEM_ADDR_BITS-1:0]      mem_addr,
    input  logic [7:0]                    mem_rdata,
    output logic                          err_out_of_range
);

    localparam int unsigned BLK_MAP_BITS = MEM_ADDR_BITS - SD_BLOCK_LENGHT_BITS;
    localparam logic [DELAY_BITS-1:0] LAT_LOAD = DELAY_BITS'(START_LATENCY - 1);
    localparam logic [DELAY_BITS-1:0] GAP_LOAD =
        (BYTE_GAP == 0) ? '0 : DELAY_BITS'(BYTE_GAP - 1);
    localparam blk_idx_t LAST_IDX = blk_idx_t'(SD_LAST_BLOCK_BYTE);

    block_resp_state_t state_q, state_d;
    blk_addr_t         blk_q, blk_d;
    blk_idx_t          idx_q, idx_d;
    logic              cont_q, cont_d;
    block_resp_beat_t  beat_q, beat_d;
    logic              ready_q, ready_d;
    logic              flag_q, flag_d;
    logic              rd_en_q, rd_en_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic                  dly_load;
    logic [DELAY_BITS-1:0] dly_val;
    logic                  dly_done;
    logic                  oor_c;
    logic                  last_c;

    block_resp_delay u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (dly_val),
        .done_c   (dly_done)
    );

`ifdef BLOCK_RESP_RANGE_CHECK_EN
    assign oor_c = (blk_q >> BLK_MAP_BITS) != '0;
`else
    assign oor_c = 1'b0;
`endif

    assign last_c = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            idx_q   <= '0;
            cont_q  <= 1'b0;
            beat_q  <= '0;
            ready_q <= 1'b0;
            flag_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            cont_q  <= cont_d;
            beat_q  <= beat_d;
            ready_q <= ready_d;
            flag_q  <= flag_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        idx_d    = idx_q;
        cont_d   = cont_q;
        beat_d   = beat_q;
        flag_d   = 1'b0;
        dly_load = 1'b0;
        dly_val  = LAT_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (ready_q && block_read_trigger) begin
                    blk_d    = block_read_block_addr;
                    cont_d   = block_read_continous_mode;
                    idx_d    = '0;
                    dly_load = 1'b1;
                    state_d  = ST_LATENCY;
                end
            end
            ST_LATENCY: begin
                if (dly_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                beat_d.data = oor_c ? 8'h00 : mem_rdata;
                beat_d.idx  = idx_q;
                flag_d      = 1'b1;
                // Last byte always takes at least one gap cycle so BLOCK_END
                // sees a trigger dropped in reaction to the final pulse.
                if ((BYTE_GAP != 0) || last_c) begin
                    dly_load = 1'b1;
                    dly_val  = GAP_LOAD;
                    state_d  = ST_GAP;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_GAP: begin
                if (dly_done) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = last_c ? ST_BLOCK_END : ST_FETCH;
                end
            end
            ST_BLOCK_END: begin
                if (cont_q && block_read_trigger) begin
                    blk_d    = blk_q + 1'b1;
                    dly_load = 1'b1;
                    state_d  = ST_LATENCY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        rd_en_d = (state_d == ST_FETCH) && !oor_c;
        addr_d  = (state_d == ST_FETCH) ? {blk_q[BLK_MAP_BITS-1:0], idx_d} : addr_q;
        err_d   = err_q | ((state_d == ST_FETCH) && oor_c);
    end

    assign block_read_card_ready    = ready_q;
    assign block_read_data          = beat_q.data;
    assign block_read_data_idx      = beat_q.idx;
    assign block_read_data_new_flag = flag_q;
    assign mem_rd_en                = rd_en_q;
    assign mem_addr                 = addr_q;
    assign err_out_of_range         = err_q;

endmodule

// File: tb/tb_sd_block_read_responder.sv
// Bench for sd_block_read_responder: table of block reads plus reset and range sequences.
module tb_sd_block_read_responder;

    typedef struct {
        int          sel;
        logic [31:0] addr;
        bit          cont;
        int          nblk;
        int          lat;
        int          per;
        int          rdy;
        bit          img;
    } rd_vec_t;

    logic        clk;
    logic        rst_n;
    logic        trig0, trig1;
    logic        cont_mode;
    logic [31:0] addr;
    bit          img_mode;

    logic        rdy0, flag0, rd_en0, err0;
    logic [7:0]  data0, rdata0;
    logic [8:0]  idx0;
    logic [19:0] maddr0;
    logic        rdy1, flag1, rd_en1, err1;
    logic [7:0]  data1, rdata1;
    logic [8:0]  idx1;
    logic [19:0] maddr1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdcnt0   = 0;
    rd_vec_t vecs[4];

    sd_block_read_responder #(.MEM_ADDR_BITS(20), .START_LATENCY(8), .BYTE_GAP(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .block_read_trigger(trig0), .block_read_continous_mode(cont_mode),
        .block_read_block_addr(addr), .block_read_card_ready(rdy0),
        .block_read_data(data0), .block_read_data_idx(idx0),
        .block_read_data_new_flag(flag0), .mem_rd_en(rd_en0),
        .mem_addr(maddr0), .mem_rdata(rdata0), .err_out_of_range(err0)
    );

    sd_block_read_responder #(.MEM_ADDR_BITS(20), .START_LATENCY(8), .BYTE_GAP(3)) dut_gap (
        .clk(clk), .rst_n(rst_n),
        .block_read_trigger(trig1), .block_read_continous_mode(cont_mode),
        .block_read_block_addr(addr), .block_read_card_ready(rdy1),
        .block_read_data(data1), .block_read_data_idx(idx1),
        .block_read_data_new_flag(flag1), .mem_rd_en(rd_en1),
        .mem_addr(maddr1), .mem_rdata(rdata1), .err_out_of_range(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Disk image: mode 0 byte n = n[7:0]; mode 1 also folds in the block number.
    function automatic logic [7:0] img_byte(logic [19:0] a, bit m);
        return m ? (a[7:0] ^ a[16:9]) : a[7:0];
    endfunction

    function automatic logic [7:0] exp_byte(logic [31:0] blk, logic [8:0] ix, bit m);
        logic [19:0] a;
`ifdef BLOCK_RESP_RANGE_CHECK_EN
        if (blk >= 32'd2048) return 8'h00;
`endif
        a = {blk[10:0], ix};
        return img_byte(a, m);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en0) begin
            rdata0 <= img_byte(maddr0, img_mode);
            rdcnt0 <= rdcnt0 + 1;
        end
        if (rd_en1) rdata1 <= img_byte(maddr1, img_mode);
    end

    function automatic logic o_rdy(int s);
        return (s == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic o_flag(int s);
        return (s == 0) ? flag0 : flag1;
    endfunction
    function automatic logic [8:0] o_idx(int s);
        return (s == 0) ? idx0 : idx1;
    endfunction
    function automatic logic [7:0] o_data(int s);
        return (s == 0) ? data0 : data1;
    endfunction

    task automatic set_trig(input int s, input logic b);
        if (s == 0) trig0 = b;
        else        trig1 = b;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one read and check every pulse's timing, index and data, then ready timing.
    task automatic do_read(input rd_vec_t v);
        int t, nb, e0, exp_t, last_t, extra;
        logic [8:0]  ix;
        logic [31:0] blk;
        img_mode = v.img;
        t = 0;
        while (o_rdy(v.sel) !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_trigger", 32'(o_rdy(v.sel)), 32'd1);
        addr      = v.addr;
        cont_mode = v.cont;
        set_trig(v.sel, 1'b1);
        @(negedge clk);
        e0 = cyc;
        chk("ready_low_after_accept", 32'(o_rdy(v.sel)), 32'd0);
        addr      = ~v.addr;
        cont_mode = ~v.cont;
        if (!v.cont) set_trig(v.sel, 1'b0);
        nb = 0; ix = '0; blk = v.addr; exp_t = e0 + v.lat; last_t = 0; t = 0;
        while (nb < v.nblk && t < 20000) begin
            if (o_flag(v.sel) === 1'b1) begin
                chk("pulse_time", 32'(cyc), 32'(exp_t));
                chk("pulse_idx", 32'(o_idx(v.sel)), 32'(ix));
                chk("pulse_data", 32'(o_data(v.sel)), 32'(exp_byte(blk, ix, v.img)));
                last_t = cyc;
                if (ix == 9'd511) begin
                    nb++;
                    blk   = blk + 1;
                    exp_t = cyc + v.rdy + v.lat;
                    if (nb == v.nblk) set_trig(v.sel, 1'b0);
                end else begin
                    exp_t = cyc + v.per;
                end
                ix = ix + 1'b1;
            end
            @(negedge clk);
            t++;
        end
        chk("blocks_completed", 32'(nb), 32'(v.nblk));
        set_trig(v.sel, 1'b0);
        t = 0; extra = 0;
        while (o_rdy(v.sel) !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
            if (o_flag(v.sel) === 1'b1) extra++;
        end
        chk("ready_after_last_pulse", 32'(cyc - last_t), 32'(v.rdy));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_flag(v.sel) === 1'b1) extra++;
        end
        chk("no_extra_pulses", 32'(extra), 32'd0);
    endtask

    initial begin
        int t, pulses, rd_before;
        rst_n = 1'b0; trig0 = 1'b0; trig1 = 1'b0; cont_mode = 1'b0;
        addr = '0; img_mode = 1'b0;

        vecs[0] = '{0, 32'd2,          1'b0, 1, 10, 2, 2, 1'b0};
        vecs[1] = '{0, 32'd5,          1'b1, 3, 10, 2, 2, 1'b1};
        vecs[2] = '{1, 32'd1,          1'b0, 1, 10, 5, 4, 1'b1};
        vecs[3] = '{0, 32'hFFFF_FFFF,  1'b1, 2, 10, 2, 2, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_flag", 32'(flag0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_idx", 32'(idx0), 32'd0);
        chk("rst_rd_en", 32'(rd_en0), 32'd0);
        chk("rst_addr", 32'(maddr0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_gap_ready", 32'(rdy1), 32'd0);
        chk("rst_gap_err", 32'(err1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(rdy0), 32'd1);

        // Block 2048 lies beyond a 1 MiB image.
        rd_before = rdcnt0;
        do_read('{0, 32'd2048, 1'b0, 1, 10, 2, 2, 1'b1});
`ifdef BLOCK_RESP_RANGE_CHECK_EN
        chk("range_rd_en_count", 32'(rdcnt0 - rd_before), 32'd0);
        chk("range_err", 32'(err0), 32'd1);
`else
        chk("range_rd_en_count", 32'(rdcnt0 - rd_before), 32'd512);
        chk("range_err", 32'(err0), 32'd0);
`endif

        for (int i = 0; i < 4; i++) do_read(vecs[i]);

        // Reset in the middle of a continuous read.
        img_mode = 1'b1; addr = 32'd9; cont_mode = 1'b1; trig0 = 1'b1;
        @(negedge clk);
        t = 0;
        while (!(flag0 === 1'b1 && idx0 == 9'd100) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reset_reached_idx100", 32'(idx0), 32'd100);
        chk("mid_reset_data_idx100", 32'(data0), 32'(exp_byte(32'd9, 9'd100, 1'b1)));
        rst_n = 1'b0; trig0 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (flag0 === 1'b1) pulses++;
        end
        chk("mid_reset_ready", 32'(rdy0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        if (flag0 === 1'b1) pulses++;
        chk("mid_reset_ready_after_release", 32'(rdy0), 32'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (flag0 === 1'b1) pulses++;
        end
        chk("mid_reset_no_pulses", 32'(pulses), 32'd0);
        do_read('{0, 32'd3, 1'b0, 1, 10, 2, 2, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
